// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream ingress arbiter and its picker.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arb_state_e;

  // Grant index width; a 2-port arbiter still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Lowest tuser bit overwritten by the source tag when tagging is enabled.
  function automatic int tag_lsb(input int user_size, input int n);
    return user_size - idx_w(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request strictly above last_idx,
// otherwise the lowest asserted request (wrap-around).
module rr_priority_picker
  import axis_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic             found_hi;
  logic             found_lo;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Two priority scans in one pass: above last_idx, and from port 0 as the wrap fallback.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int p = 0; p < N; p++) begin
      if (req[p] && !found_hi && (IDX_W'(p) > last_idx)) begin
        found_hi = 1'b1;
        hi_idx   = IDX_W'(p);
      end
      if (req[p] && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = IDX_W'(p);
      end
    end
  end

  assign grant_idx = found_hi ? hi_idx : lo_idx;
  assign any_req   = found_lo;

endmodule

// File: rtl/axi_stream_ingress_arbiter.sv
// Packet-granular round-robin merge of NUM_INGRESS_PORTS AXI-Stream sources with oversize truncation.
// Optional feature macro AXIS_ARB_SRC_TAG_EN: stamps the grant index into the top bits of m_tuser.
module axi_stream_ingress_arbiter
  import axis_arb_pkg::*;
#(
  parameter int  DATA_SIZE         = 32,
  parameter int  USER_SIZE         = 16,
  parameter int  NUM_INGRESS_PORTS = 3,
  parameter int  MAX_PKT_SIZE      = 1024,
  localparam int IDX_W             = idx_w(NUM_INGRESS_PORTS),
  localparam int KEEP_W            = DATA_SIZE / 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_INGRESS_PORTS*DATA_SIZE-1:0] s_tdata,
  input  logic [NUM_INGRESS_PORTS*KEEP_W-1:0]    s_tkeep,
  input  logic [NUM_INGRESS_PORTS*USER_SIZE-1:0] s_tuser,
  input  logic [NUM_INGRESS_PORTS-1:0]           s_tlast,
  input  logic [NUM_INGRESS_PORTS-1:0]           s_tvalid,
  output logic [NUM_INGRESS_PORTS-1:0]           s_tready,
  output logic [DATA_SIZE-1:0]                   m_tdata,
  output logic [KEEP_W-1:0]                      m_tkeep,
  output logic [USER_SIZE-1:0]                   m_tuser,
  output logic                                   m_tlast,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic [IDX_W-1:0]                       grant_idx,
  output logic                                   busy,
  output logic                                   err_oversize
);

  localparam int               CNT_W      = $clog2(MAX_PKT_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(MAX_PKT_SIZE - 1);
  localparam logic [IDX_W-1:0] RESET_LAST = IDX_W'(NUM_INGRESS_PORTS - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_oversize_q, err_oversize_d;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [DATA_SIZE-1:0] sel_data;
  logic [KEEP_W-1:0]    sel_keep;
  logic [USER_SIZE-1:0] sel_user;
  logic                 sel_last;
  logic                 sel_valid;
  logic                 pass;
  logic                 at_limit;
  logic                 eff_last;
  logic                 handshake;

  rr_priority_picker #(
    .N     (NUM_INGRESS_PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req       (s_tvalid),
    .last_idx  (last_grant_q),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int p = 0; p < NUM_INGRESS_PORTS; p++) begin
      if (grant_q == IDX_W'(p)) begin
        sel_data  = s_tdata[p*DATA_SIZE +: DATA_SIZE];
        sel_keep  = s_tkeep[p*KEEP_W +: KEEP_W];
        sel_user  = s_tuser[p*USER_SIZE +: USER_SIZE];
        sel_last  = s_tlast[p];
        sel_valid = s_tvalid[p];
      end
    end
  end

  // Beat MAX_PKT_SIZE of a packet is closed off even if the source has not finished it.
  assign pass      = (state_q == ARB_PASS);
  assign at_limit  = (beat_cnt_q == LAST_BEAT);
  assign eff_last  = sel_last | at_limit;
  assign m_tvalid  = pass & sel_valid;
  assign handshake = m_tvalid & m_tready;
  assign m_tdata   = sel_data;
  assign m_tkeep   = sel_keep;
  assign m_tlast   = pass & eff_last;

  always_comb begin
    s_tready = '0;
    if (pass) begin
      for (int p = 0; p < NUM_INGRESS_PORTS; p++) begin
        if (grant_q == IDX_W'(p)) begin
          s_tready[p] = m_tready;
        end
      end
    end
  end

`ifdef AXIS_ARB_SRC_TAG_EN
  localparam int TAG_LSB = tag_lsb(USER_SIZE, NUM_INGRESS_PORTS);

  always_comb begin
    m_tuser                       = sel_user;
    m_tuser[USER_SIZE-1:TAG_LSB] = grant_q;
  end
`else
  assign m_tuser = sel_user;
`endif

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    beat_cnt_d     = beat_cnt_q;
    err_oversize_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ARB_PASS;
        end
      end
      ARB_PASS: begin
        if (handshake) begin
          if (eff_last) begin
            state_d        = ARB_IDLE;
            last_grant_d   = grant_q;
            beat_cnt_d     = '0;
            err_oversize_d = at_limit & ~sel_last;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB_IDLE;
      grant_q        <= '0;
      last_grant_q   <= RESET_LAST;
      beat_cnt_q     <= '0;
      err_oversize_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      beat_cnt_q     <= beat_cnt_d;
      err_oversize_q <= err_oversize_d;
    end
  end

  assign grant_idx    = grant_q;
  assign busy         = pass;
  assign err_oversize = err_oversize_q;

endmodule
